// File: rtl/mmcm_reset_seq_if.sv
// Signal bundle between the MMCM reset sequencer and the FPGA top level.
// master: the side that drives the reset requests and LOCKED (board / testbench).
// slave:  the sequencer itself.
interface mmcm_reset_seq_if;
  logic       btn_rst_i;
  logic       ext_rst_i;
  logic       mmcm_locked_i;
  logic       mmcm_rst_o;
  logic       core_rst_n_o;
  logic       lock_fail_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;

  modport master (
    output btn_rst_i,
    output ext_rst_i,
    output mmcm_locked_i,
    input  mmcm_rst_o,
    input  core_rst_n_o,
    input  lock_fail_o,
    input  state_o,
    input  retry_cnt_o,
    input  lock_loss_cnt_o
  );

  modport slave (
    input  btn_rst_i,
    input  ext_rst_i,
    input  mmcm_locked_i,
    output mmcm_rst_o,
    output core_rst_n_o,
    output lock_fail_o,
    output state_o,
    output retry_cnt_o,
    output lock_loss_cnt_o
  );
endinterface

// File: rtl/mmcm_reset_seq.sv
// MMCM reset / lock sequencer on the free-running board clock.
// Debounces button and pin reset requests, pulses MMCM RST, waits for LOCKED with
// timeout and retry limit, then releases the active-low core reset after a stable-lock delay.
// Optional: define MMCM_LOCK_LOSS_CNT_EN to build the saturating lock-loss event counter;
// otherwise lock_loss_cnt_o is tied to zero.
module mmcm_reset_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 1200,
  parameter int unsigned MMCM_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT    = 120000,
  parameter int unsigned RELEASE_DELAY   = 64,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic              clk,
  input  logic              rst,
  mmcm_reset_seq_if.slave   bus
);

  localparam logic [2:0] StAssertRst = 3'd0;
  localparam logic [2:0] StWaitLock  = 3'd1;
  localparam logic [2:0] StStretch   = 3'd2;
  localparam logic [2:0] StRun       = 3'd3;
  localparam logic [2:0] StFail      = 3'd4;

  localparam int unsigned MaxAB  = (LOCK_TIMEOUT > RELEASE_DELAY) ? LOCK_TIMEOUT : RELEASE_DELAY;
  localparam int unsigned MaxCyc = (MaxAB > MMCM_RST_CYCLES) ? MaxAB : MMCM_RST_CYCLES;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TimerW-1:0] RstLast     = TimerW'(MMCM_RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] ReleaseLast = TimerW'(RELEASE_DELAY - 1);
  localparam logic [DebW-1:0]   DebLast     = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]        RetrySat    = 2'(MAX_RETRY);

  logic [1:0]        btn_sync_q, btn_sync_d;
  logic [1:0]        ext_sync_q, ext_sync_d;
  logic [1:0]        lock_sync_q, lock_sync_d;
  logic              deb_lvl_q, deb_lvl_d;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [2:0]        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        retry_q, retry_d;
  logic              fail_q, fail_d;
  logic              mmcm_rst_q, mmcm_rst_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic raw_req;
  logic req_evt;
  logic locked;
  logic lock_loss_inc;

  // Two-flop synchronizers for the three asynchronous inputs.
  always_comb begin
    btn_sync_d  = {btn_sync_q[0], bus.btn_rst_i};
    ext_sync_d  = {ext_sync_q[0], bus.ext_rst_i};
    lock_sync_d = {lock_sync_q[0], bus.mmcm_locked_i};
  end

  assign raw_req = btn_sync_q[1] | ext_sync_q[1];
  assign locked  = lock_sync_q[1];

  // Debounce: level follows the raw request only after DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    deb_lvl_d = deb_lvl_q;
    deb_cnt_d = '0;
    req_evt   = 1'b0;
    if (raw_req != deb_lvl_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_lvl_d = raw_req;
        req_evt   = raw_req;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Sequencer next state; a request event overrides every other transition.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    fail_d        = fail_q;
    lock_loss_inc = 1'b0;
    if (req_evt) begin
      state_d = StAssertRst;
      timer_d = '0;
      retry_d = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        StAssertRst: begin
          // Hold MMCM in reset for as long as the debounced request stays high.
          if (deb_lvl_q) begin
            timer_d = '0;
          end else if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (locked) begin
            state_d = StStretch;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            timer_d = '0;
            if ({30'd0, retry_q} < MAX_RETRY - 1) begin
              retry_d = retry_q + 2'd1;
              state_d = StAssertRst;
            end else begin
              retry_d = RetrySat;
              fail_d  = 1'b1;
              state_d = StFail;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StStretch: begin
          if (!locked) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == ReleaseLast) begin
            state_d = StRun;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StRun: begin
          if (!locked) begin
            state_d       = StAssertRst;
            timer_d       = '0;
            lock_loss_inc = 1'b1;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StAssertRst;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_comb begin
    mmcm_rst_d   = (state_d == StAssertRst) || (state_d == StFail);
    core_rst_n_d = (state_d == StRun);
  end

  // State, debounce and synchronizer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_q   <= '0;
      ext_sync_q   <= '0;
      lock_sync_q  <= '0;
      deb_lvl_q    <= 1'b0;
      deb_cnt_q    <= '0;
      state_q      <= StAssertRst;
      timer_q      <= '0;
      retry_q      <= '0;
      fail_q       <= 1'b0;
      mmcm_rst_q   <= 1'b1;
      core_rst_n_q <= 1'b0;
    end else begin
      btn_sync_q   <= btn_sync_d;
      ext_sync_q   <= ext_sync_d;
      lock_sync_q  <= lock_sync_d;
      deb_lvl_q    <= deb_lvl_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      fail_q       <= fail_d;
      mmcm_rst_q   <= mmcm_rst_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

`ifdef MMCM_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating lock-loss counter; only rst clears it.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_loss_inc && (loss_cnt_q != 8'hff)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  // Lock-loss counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign bus.lock_loss_cnt_o = loss_cnt_q;
`else
  logic unused_lock_loss_inc;
  assign unused_lock_loss_inc = lock_loss_inc;
  assign bus.lock_loss_cnt_o  = 8'd0;
`endif

  assign bus.mmcm_rst_o   = mmcm_rst_q;
  assign bus.core_rst_n_o = core_rst_n_q;
  assign bus.lock_fail_o  = fail_q;
  assign bus.state_o      = state_q;
  assign bus.retry_cnt_o  = retry_q;

endmodule
